// File: rtl/uart_slot_ctrl.sv
// Polling controller for a memory-mapped UART slot: divisor writes, TX pushes and RX pops.
// Optional RX idle timeout enabled by defining UART_CTRL_RX_TIMEOUT_EN.
module uart_slot_ctrl #(
  parameter logic [10:0] DVSR_INIT      = 11'd650,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] dvsr_in,
  input  logic        dvsr_ld,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        cs,
  output logic        read,
  output logic        write,
  output logic [4:0]  addr,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  output logic        rx_timeout
);

  typedef enum logic [2:0] {INIT, POLL, ARB, DVSR, TX, RX} state_e;

  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_DVSR   = 5'd1;
  localparam logic [4:0] ADDR_FIFO   = 5'd2;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [10:0] dvsr_q, dvsr_d;
  logic        tx_full_q, tx_full_d;
  logic        rx_empty_q, rx_empty_d;
  logic        last_rx_q, last_rx_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_elig, rx_elig;
  logic        unused_rd;

  assign unused_rd = ^rd_data[31:10];

  assign tx_elig = tx_valid && !tx_full_q;
  assign rx_elig = !rx_empty_q && !rx_valid_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: state_d = POLL;
      POLL: state_d = ARB;
      ARB: begin
        if (pend_q)                  state_d = DVSR;
        else if (tx_elig && rx_elig) state_d = last_rx_q ? TX : RX;
        else if (tx_elig)            state_d = TX;
        else if (rx_elig)            state_d = RX;
        else                         state_d = POLL;
      end
      DVSR, TX, RX: state_d = POLL;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    cs       = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    addr     = ADDR_STATUS;
    wr_data  = 32'd0;
    tx_ready = 1'b0;
    unique case (state_q)
      INIT: begin
        cs = 1'b1; write = 1'b1; addr = ADDR_DVSR;
        wr_data = {21'd0, DVSR_INIT};
      end
      POLL: begin
        cs = 1'b1; read = 1'b1; addr = ADDR_STATUS;
      end
      DVSR: begin
        cs = 1'b1; write = 1'b1; addr = ADDR_DVSR;
        wr_data = {21'd0, dvsr_q};
      end
      TX: begin
        cs = 1'b1; write = 1'b1; addr = ADDR_FIFO;
        wr_data  = {24'd0, tx_data};
        tx_ready = 1'b1;
      end
      RX: begin
        cs = 1'b1; read = 1'b1; addr = ADDR_FIFO;
      end
      default: ;
    endcase
  end

  // A load arriving in the DVSR cycle wins over the clear, so the new value is still written.
  always_comb begin
    pend_d     = pend_q;
    dvsr_d     = dvsr_q;
    tx_full_d  = tx_full_q;
    rx_empty_d = rx_empty_q;
    last_rx_d  = last_rx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (state_q == DVSR) pend_d = 1'b0;
    if (dvsr_ld) begin
      pend_d = 1'b1;
      dvsr_d = dvsr_in;
    end
    if (state_q == POLL) begin
      tx_full_d  = rd_data[9];
      rx_empty_d = rd_data[8];
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (state_q == TX) last_rx_d = 1'b0;
    if (state_q == RX) begin
      last_rx_d  = 1'b1;
      rx_data_d  = rd_data[7:0];
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      dvsr_q     <= 11'd0;
      tx_full_q  <= 1'b1;
      rx_empty_q <= 1'b1;
      last_rx_q  <= 1'b1;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      dvsr_q     <= dvsr_d;
      tx_full_q  <= tx_full_d;
      rx_empty_q <= rx_empty_d;
      last_rx_q  <= last_rx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef UART_CTRL_RX_TIMEOUT_EN
  localparam int             CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             got_byte_q, got_byte_d;

  always_comb begin
    to_cnt_d   = to_cnt_q;
    got_byte_d = got_byte_q;
    if (state_q == RX) begin
      to_cnt_d   = '0;
      got_byte_d = 1'b1;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q   <= '0;
      got_byte_q <= 1'b0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      got_byte_q <= got_byte_d;
    end
  end

  assign rx_timeout = got_byte_q && (to_cnt_q == TO_MAX);
`else
  logic [31:0] unused_to;

  assign unused_to  = TIMEOUT_CYCLES;
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_slot_ctrl.sv
// Directed bench for uart_slot_ctrl with a combinational UART slot model.
// Honours UART_CTRL_RX_TIMEOUT_EN the same way as the design.
module tb_uart_slot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr_in;
  logic        dvsr_ld;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rx_timeout;

  logic        m_tx_full, m_rx_empty;
  logic [7:0]  m_rx_byte;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Slot model: status at 0, FIFO byte at 2, combinational from addr.
  assign rd_data = (addr == 5'd0) ? {22'd0, m_tx_full, m_rx_empty, 8'd0} :
                   (addr == 5'd2) ? {24'd0, m_rx_byte} : 32'd0;

  uart_slot_ctrl #(.DVSR_INIT(11'd650), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .dvsr_in(dvsr_in), .dvsr_ld(dvsr_ld),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rx_timeout(rx_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_strobes(input string tag, input logic c, input logic r, input logic w,
                             input logic [4:0] a, input logic [31:0] d);
    chk({tag, " strobes"}, {29'd0, cs, read, write}, {29'd0, c, r, w});
    chk({tag, " addr"}, {27'd0, addr}, {27'd0, a});
    chk({tag, " wr_data"}, wr_data, d);
  endtask

  task automatic sync_poll(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      found = cs && read && (addr == 5'd0);
    end
    chk({tag, " reached POLL"}, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_rx_read(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      found = cs && read && (addr == 5'd2);
    end
    chk({tag, " RX read seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_tx_ready(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      found = tx_ready;
    end
    chk({tag, " tx_ready seen"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int bad;
    int seen;
    reset = 1'b1; dvsr_in = '0; dvsr_ld = 1'b0; tx_data = '0; tx_valid = 1'b0;
    rx_ready = 1'b0; m_tx_full = 1'b0; m_rx_empty = 1'b1; m_rx_byte = 8'h00;
    tick(); tick();

    // Reset state, and the first cycle after release is the INIT divisor write
    chk("reset tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset rx_timeout", {31'd0, rx_timeout}, 32'd0);
    reset = 1'b0;
    chk_strobes("init", 1'b1, 1'b0, 1'b1, 5'd1, 32'd650);
    tick();
    chk_strobes("first poll", 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);

    // Tie right after reset: TX wins, then RX, and alternation continues
    tx_valid = 1'b1; tx_data = 8'hA5; m_rx_empty = 1'b0; m_rx_byte = 8'h3C; rx_ready = 1'b1;
    tick();
    chk_strobes("arb idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("tie tx_ready", {31'd0, tx_ready}, 32'd1);
    chk_strobes("tie tx", 1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_00A5);
    tick(); tick(); tick();
    chk_strobes("tie rx", 1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    chk("rx-state tx_ready", {31'd0, tx_ready}, 32'd0);
    tick();
    chk("rx_valid after RX", {31'd0, rx_valid}, 32'd1);
    chk("rx_data after RX", {24'd0, rx_data}, 32'h3C);
    tick();
    chk("rx_valid cleared by rx_ready", {31'd0, rx_valid}, 32'd0);
    tick();
    chk("alternate tx_ready", {31'd0, tx_ready}, 32'd1);
    tick(); tick(); tick();
    chk_strobes("alternate rx", 1'b1, 1'b1, 1'b0, 5'd2, 32'd0);

    // Consumer stalls: no RX read while rx_valid is held
    rx_ready = 1'b0; tx_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cs && read && addr == 5'd2) bad++;
    end
    chk("stall RX reads", bad, 0);
    chk("stall rx_valid held", {31'd0, rx_valid}, 32'd1);
    m_rx_byte = 8'hC3; rx_ready = 1'b1;
    wait_rx_read("resume");
    rx_ready = 1'b0; m_rx_empty = 1'b1;
    tick();
    chk("resume rx_data", {24'd0, rx_data}, 32'hC3);
    chk("resume rx_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;

    // TX FIFO full: no write strobe and no tx_ready until space appears
    m_tx_full = 1'b1;
    sync_poll("full");
    tx_valid = 1'b1; tx_data = 8'h77;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (write || tx_ready) bad++;
    end
    chk("full no write", bad, 0);
    m_tx_full = 1'b0;
    wait_tx_ready("unfull");
    chk("unfull wr_data", wr_data, 32'h77);
    tx_valid = 1'b0;

    // Basic TX: tx_ready on the third cycle from POLL entry
    sync_poll("tx55");
    tx_valid = 1'b1; tx_data = 8'h55;
    tick();
    chk("tx55 arb no tx_ready", {31'd0, tx_ready}, 32'd0);
    tick();
    chk("tx55 tx_ready", {31'd0, tx_ready}, 32'd1);
    chk_strobes("tx55", 1'b1, 1'b0, 1'b1, 5'd2, 32'h55);
    tx_valid = 1'b0;
    tick();
    chk("tx55 single pulse", {31'd0, tx_ready}, 32'd0);

    // Divisor load preempts pending TX; reload in DVSR cycle is written again
    sync_poll("dvsr");
    tx_valid = 1'b1; tx_data = 8'h99; dvsr_in = 11'd325; dvsr_ld = 1'b1;
    tick();
    dvsr_ld = 1'b0;
    tick();
    chk_strobes("dvsr 325", 1'b1, 1'b0, 1'b1, 5'd1, 32'd325);
    chk("dvsr tx_ready", {31'd0, tx_ready}, 32'd0);
    dvsr_in = 11'd100; dvsr_ld = 1'b1;
    tick();
    dvsr_ld = 1'b0;
    tick(); tick();
    chk_strobes("dvsr 100", 1'b1, 1'b0, 1'b1, 5'd1, 32'd100);
    tick(); tick(); tick();
    chk("post-dvsr tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("post-dvsr wr_data", wr_data, 32'h99);
    tx_valid = 1'b0;

    // Reset in ARB with a TX pending aborts it without tx_ready
    sync_poll("abort");
    tx_valid = 1'b1; tx_data = 8'h11;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; tx_valid = 1'b0;
    chk("abort tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("abort rx_data", {24'd0, rx_data}, 32'd0);
    chk_strobes("abort init", 1'b1, 1'b0, 1'b1, 5'd1, 32'd650);
    tick();
    chk_strobes("abort poll", 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);

    // RX idle timeout: never before a byte, then set after idle, cleared by next RX
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rx_timeout) seen++;
    end
    chk("no byte no timeout", seen, 0);
    m_rx_empty = 1'b0; m_rx_byte = 8'h5A;
    wait_rx_read("to byte1");
    m_rx_empty = 1'b1;
    tick();
    chk("to byte1 rx_data", {24'd0, rx_data}, 32'h5A);
    seen = 0;
    for (int i = 0; i < 55 && seen == 0; i++) begin
      tick();
      if (rx_timeout) seen = 1;
    end
`ifdef UART_CTRL_RX_TIMEOUT_EN
    chk("timeout raised", seen, 1);
`else
    chk("timeout tied low", seen, 0);
`endif
    m_rx_empty = 1'b0; m_rx_byte = 8'h6B;
    wait_rx_read("to byte2");
    m_rx_empty = 1'b1;
    tick();
    chk("timeout cleared by RX", {31'd0, rx_timeout}, 32'd0);
    chk("to byte2 rx_data", {24'd0, rx_data}, 32'h6B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
